// File: rtl/sifh_zoom_scheduler.sv
// Coarse-to-fine zoom sequencer for the shared SiFH histogram datapath.
// Runs every pixel through a coarse pass plus NSTEP refinements and reports one ToF per pixel.
module sifh_zoom_scheduler #(
  parameter int unsigned NP      = 12,
  parameter int unsigned NB      = 4,
  parameter int unsigned ZS      = 2,
  parameter int unsigned PIXELS  = 2,
  parameter int unsigned TIMEOUT = 1023,
  localparam int unsigned PW     = (PIXELS > 1) ? $clog2(PIXELS) : 1,
  localparam int unsigned EW     = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          hist_start,
  output logic [PW-1:0] hist_pixel,
  output logic [NP-1:0] hist_lo,
  output logic [EW-1:0] hist_exp,
  input  logic          peak_done,
  input  logic [NB-1:0] peak_ch,
  output logic          res_valid,
  output logic [PW-1:0] res_pixel,
  output logic [NP-1:0] res_tof,
  output logic          res_err
);

  localparam int unsigned NSTEP = (NP - NB) / ZS;
  localparam int unsigned SW    = (NSTEP > 0) ? $clog2(NSTEP + 1) : 1;
  localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned LW    = NP + 1;
  localparam logic [LW-1:0] ONE = LW'(1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT, ST_UPDATE, ST_NEXT, ST_DONE
  } stateT;

  stateT           state;
  logic [SW-1:0]   sCnt;
  logic [PW-1:0]   pCnt;
  logic [TW-1:0]   wdog;
  logic [NB-1:0]   peakReg;
  logic [NP-1:0]   loTab [PIXELS];
  logic [PIXELS-1:0] errFlag;

  logic [LW-1:0]   base, cVal, rnd, half, hiLim, nVal;
  logic [NP-1:0]   newLo, finalTof;
  int unsigned     eSh, hSh;
  logic            lastPix, lastStep, curErr, nextErr;
  logic [PW-1:0]   nextP;
  logic [SW-1:0]   nextS;

  function automatic logic [EW-1:0] expOf(input logic [SW-1:0] s);
    return EW'(NP - NB - ZS * 32'(s));
  endfunction

  // Recentre on the peak bin at NP+1 bits, then clamp into [0, 2^NP - next window width].
  always_comb begin
    eSh      = NP - NB - ZS * 32'(sCnt);
    hSh      = NP - ZS * (32'(sCnt) + 32'd1);
    base     = (sCnt == '0) ? '0 : LW'(loTab[pCnt]);
    rnd      = (eSh > 0) ? (ONE << (eSh - 1)) : '0;
    cVal     = base + (LW'(peakReg) << eSh) + rnd;
    half     = ONE << (hSh - 1);
    hiLim    = (ONE << NP) - (ONE << hSh);
    nVal     = (cVal < half) ? '0 : cVal - half;
    if (nVal > hiLim) nVal = hiLim;
    newLo    = NP'(nVal);
    finalTof = NP'(base + LW'(peakReg));
  end

  // Step-major advance: pixel index is the inner loop.
  always_comb begin
    lastPix  = (pCnt == PW'(PIXELS - 1));
    nextP    = lastPix ? '0 : pCnt + PW'(1);
    nextS    = lastPix ? sCnt + SW'(1) : sCnt;
    lastStep = lastPix && (sCnt == SW'(NSTEP));
    curErr   = errFlag[pCnt];
    nextErr  = errFlag[nextP];
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      hist_start <= 1'b0;
      hist_pixel <= '0;
      hist_lo    <= '0;
      hist_exp   <= '0;
      res_valid  <= 1'b0;
      res_pixel  <= '0;
      res_tof    <= '0;
      res_err    <= 1'b0;
      sCnt       <= '0;
      pCnt       <= '0;
      wdog       <= '0;
      peakReg    <= '0;
      errFlag    <= '0;
      for (int i = 0; i < PIXELS; i++) loTab[i] <= '0;
    end else begin
      hist_start <= 1'b0;
      res_valid  <= 1'b0;
      done       <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              errFlag    <= '0;
              sCnt       <= '0;
              pCnt       <= '0;
              busy       <= 1'b1;
              hist_start <= 1'b1;
              hist_pixel <= '0;
              hist_lo    <= '0;
              hist_exp   <= expOf('0);
              state      <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            wdog  <= '0;
            state <= ST_WAIT;
          end
          // peak_done outranks a simultaneous watchdog expiry
          ST_WAIT: begin
            if (peak_done) begin
              peakReg <= peak_ch;
              state   <= ST_UPDATE;
            end else if (wdog == TW'(TIMEOUT - 1)) begin
              errFlag[pCnt] <= 1'b1;
              state         <= ST_UPDATE;
            end else begin
              wdog <= wdog + TW'(1);
            end
          end
          ST_UPDATE: begin
            if (sCnt == SW'(NSTEP)) begin
              res_valid <= 1'b1;
              res_pixel <= pCnt;
              res_err   <= curErr;
              res_tof   <= curErr ? '0 : finalTof;
            end else if (!curErr) begin
              loTab[pCnt] <= newLo;
            end
            state <= ST_NEXT;
          end
          ST_NEXT: begin
            if (lastStep) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end else begin
              sCnt <= nextS;
              pCnt <= nextP;
              if (nextErr) begin
                state <= ST_UPDATE;
              end else begin
                hist_start <= 1'b1;
                hist_pixel <= nextP;
                hist_lo    <= (nextS == '0) ? '0 : loTab[nextP];
                hist_exp   <= expOf(nextS);
                state      <= ST_ISSUE;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/sifh_zoom_scheduler.md
# sifh_zoom_scheduler

Sequences the shared SiFH histogram/peak/algebraic datapath through a coarse-to-fine zoom for every pixel of a RAM group. Each pixel gets one coarse pass over the full timestamp range, then a fixed number of refinement passes. Before each refinement, the block recentres and clamps the pixel's window on the last peak bin. It sits between the frame controller (start/done) and the histogram engine (hist_start/peak_done), holds the per-pixel window table, and emits one final ToF per pixel.

## Interface
- NP, 12, timestamp width in bits; the full range is 0..2^NP-1
- NB, 4, histogram bin-index width (2^NB bins per pass)
- ZS, 2, zoom shift: each pass shrinks the window by 2^ZS. (NP-NB) must be divisible by ZS; NSTEP=(NP-NB)/ZS.
- PIXELS, 2, pixels sequenced per run (PW=clog2(PIXELS), minimum 1)
- TIMEOUT, 1023, maximum cycles to wait for peak_done
- clk  in  1  clock
- res  in  1  reset; asynchronous and active-high
- start  in  1  one-cycle run request
- abort  in  1  synchronous abort
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when a run completes
- hist_start  out  1  one-cycle histogram request
- hist_pixel  out  PW  pixel under test
- hist_lo  out  NP  window base
- hist_exp  out  clog2(NP)  bin-width exponent e = NP-NB-s*ZS
- peak_done  in  1  peak result valid
- peak_ch  in  NB  peak bin index
- res_valid  out  1  one-cycle final-result pulse
- res_pixel  out  PW  pixel of the result
- res_tof  out  NP  final ToF
- res_err  out  1  pixel timed out at some pass

## Operation
- States:
  - IDLE: when start is seen, clear the err flags, set s=0, p=0, and go to ISSUE.
  - ISSUE: pulse hist_start for one cycle, then go to WAIT. Pixels with err=1 skip ISSUE/WAIT and go straight to UPDATE.
  - WAIT: on peak_done, capture peak_ch and go to UPDATE. On expiry of the watchdog counter (TIMEOUT cycles), set err[p] and go to UPDATE.
  - UPDATE: perform the window update below, then go to NEXT.
  - NEXT: advance p. When p wraps, advance s. After s=NSTEP and p=PIXELS-1, go to DONE; otherwise go to ISSUE.
  - DONE: pulse done and return to IDLE.
- Order: step-major. All pixels run pass s before any pixel runs pass s+1.
- Window base: hist_lo = 0 when s=0, otherwise lo[p].
- Window update for s<NSTEP, computed at NP+1 bits:
  - c = lo + (peak<<e) + (e>0 ? 1<<(e-1) : 0)
  - half = 2^(NP-(s+1)*ZS-1)
  - n = (c<half) ? 0 : c-half
  - if n > 2^NP - 2^(NP-(s+1)*ZS), clamp n to that value
  - write lo[p] = n
- Final pass (s=NSTEP, e=0): pulse res_valid with res_tof = lo+peak, which never overflows.
- Errored pixel: lo[p] is left unchanged. Its final res_valid carries res_err=1 and res_tof=0.
- Ignored inputs: start while busy; peak_done outside WAIT.
- abort: in any non-IDLE state, go to IDLE on the next edge. No done or res_valid is issued; the lo table contents are don't-care.
- Reset: every output is 0, the state is IDLE, and the lo table and err flags are cleared.

## Timing
- Start: start at cycle t puts ISSUE at t+1, with busy and hist_start high that cycle. hist_pixel, hist_lo and hist_exp are valid with hist_start and held stable through WAIT.
- Peak handshake: peak_done at cycle u puts UPDATE at u+1. res_valid, res_pixel, res_tof and res_err are registered and high for exactly the cycle after UPDATE. The next hist_start follows at u+3.
- peak_done in the same cycle as hist_start is ignored; the earliest accepted peak_done is in the cycle after hist_start.
- Timeout: the watchdog counter resets on entering WAIT. When peak_done and expiry happen in the same cycle, peak_done wins.
- Completion: done pulses the cycle after the last NEXT. busy falls in that same cycle. A new start is accepted from the following cycle.
- abort has priority over peak_done and over timeout.

## Test plan
- Coarse pass, PIXELS=1, s=0, peak_ch=5 → hist_exp=8, hist_lo=0; lo becomes 1408-512 = 896. s=1, peak 15 → c=1888, lo=1760.
- Low and high clamp at s=0: peak 0 → lo=0; peak 15 → c=3968, clamped to 3072.
- Full run, PIXELS=2, peak always 15 → 10 hist_start pulses; hist_lo sequence 0, 3072, 3840, 4032, 4080; res_tof=4095 for both pixels; done once. Repeat with peak always 0 → res_tof=0.
- Timeout: TIMEOUT=15, pixel 1 gets no peak_done at s=1 → watchdog expires after 15 cycles; pixel 1 gets no further hist_start; final result res_err=1, res_tof=0. Pixel 0 is unaffected.
- abort during WAIT at s=2 → IDLE next cycle with busy=0, no done and no res_valid. A following start restarts at s=0 with hist_lo=0.
- Reset asserted mid-WAIT → all outputs 0 immediately. Stray peak_done and start while busy are ignored (no extra res_valid or hist_start).
